// File: rtl/clk_divider_prog.sv
// Programmable clock divider: clk_div is high for H cycles and low for N-H cycles, and tick marks each period start.
// A new N/H is accepted over valid/ready and takes effect only at a period boundary.
//   state | meaning
//   IDLE  | stopped, outputs low, accepted config goes straight to cur_*
//   RUN   | counting periods, accepted config waits in pending until wrap
module clk_divider_prog #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_DIV  = 64,
  parameter int unsigned DEFAULT_HIGH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_div,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] cur_high
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] cur_high_q, cur_high_d;

  logic [CNT_W-1:0] clamp_div, clamp_high, count_inc;
  logic             accept, wrap;

  // Requested values are clamped once, at acceptance, so cur_* always hold a legal N/H pair.
  always_comb begin
    clamp_div = (cfg_div < TWO) ? TWO : cfg_div;
    if (cfg_high == '0) begin
      clamp_high = ONE;
    end else if (cfg_high >= clamp_div) begin
      clamp_high = clamp_div - ONE;
    end else begin
      clamp_high = cfg_high;
    end
  end

  assign accept    = cfg_valid && !pending_q;
  assign wrap      = (count_q == cur_div_q - ONE);
  assign count_inc = count_q + ONE;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clk_div_d   = clk_div_q;
    tick_d      = 1'b0;
    pending_d   = pending_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    cur_div_d   = cur_div_q;
    cur_high_d  = cur_high_q;

    case (state_q)
      ST_IDLE: begin
        count_d   = '0;
        clk_div_d = 1'b0;
        if (accept) begin
          cur_div_d  = clamp_div;
          cur_high_d = clamp_high;
        end
        if (en) begin
          state_d   = ST_RUN;
          clk_div_d = 1'b1;
          tick_d    = 1'b1;
        end
      end

      ST_RUN: begin
        if (!en) begin
          state_d   = ST_IDLE;
          count_d   = '0;
          clk_div_d = 1'b0;
          // Leaving RUN means no period is in progress, so any new config can land directly.
          if (pending_q) begin
            cur_div_d  = pend_div_q;
            cur_high_d = pend_high_q;
            pending_d  = 1'b0;
          end else if (accept) begin
            cur_div_d  = clamp_div;
            cur_high_d = clamp_high;
          end
        end else if (wrap) begin
          count_d   = '0;
          clk_div_d = 1'b1;
          tick_d    = 1'b1;
          // A request accepted on the wrap edge itself waits for the next wrap.
          if (pending_q) begin
            cur_div_d  = pend_div_q;
            cur_high_d = pend_high_q;
            pending_d  = 1'b0;
          end else if (accept) begin
            pend_div_d  = clamp_div;
            pend_high_d = clamp_high;
            pending_d   = 1'b1;
          end
        end else begin
          count_d   = count_inc;
          clk_div_d = (count_inc < cur_high_q);
          if (accept) begin
            pend_div_d  = clamp_div;
            pend_high_d = clamp_high;
            pending_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        count_d   = '0;
        clk_div_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      clk_div_q   <= 1'b0;
      tick_q      <= 1'b0;
      pending_q   <= 1'b0;
      pend_div_q  <= DIV_RST;
      pend_high_q <= HIGH_RST;
      cur_div_q   <= DIV_RST;
      cur_high_q  <= HIGH_RST;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clk_div_q   <= clk_div_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      cur_div_q   <= cur_div_d;
      cur_high_q  <= cur_high_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign cur_div   = cur_div_q;
  assign cur_high  = cur_high_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed scenarios with literal expectations, plus a cycle-level
// model tracking period start times in absolute cycles.
module tb_clk_divider_prog;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_ready, clk_div, tick;
  logic [W-1:0] cur_div, cur_high;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  clk_divider_prog #(.CNT_W(W), .DEFAULT_DIV(64), .DEFAULT_HIGH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_div(clk_div), .tick(tick),
    .cur_div(cur_div), .cur_high(cur_high)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a period begins at cycle m_start; the output phase is simply the cycles elapsed since then.
  int cyc, m_start, m_n, m_h, m_pn, m_ph;
  bit m_run, m_pend;

  always @(posedge clk or posedge rst) begin
    bit acc;
    int nn, hh;
    if (rst) begin
      m_run = 0; m_pend = 0; m_n = 64; m_h = 32; m_pn = 0; m_ph = 0;
      cyc = 0; m_start = 0;
    end else begin
      acc = cfg_valid && !m_pend;
      nn = (cfg_div < 2) ? 2 : int'(cfg_div);
      hh = (cfg_high == 0) ? 1 : ((int'(cfg_high) >= nn) ? nn - 1 : int'(cfg_high));
      cyc++;
      if (!m_run) begin
        if (acc) begin m_n = nn; m_h = hh; end
        if (en) begin m_run = 1; m_start = cyc; end
      end else if (!en) begin
        m_run = 0;
        if (m_pend) begin m_n = m_pn; m_h = m_ph; m_pend = 0; end
        else if (acc) begin m_n = nn; m_h = hh; end
      end else begin
        if (cyc - m_start == m_n) begin
          m_start = cyc;
          if (m_pend) begin m_n = m_pn; m_h = m_ph; m_pend = 0; acc = 0; end
        end
        if (acc) begin m_pn = nn; m_ph = hh; m_pend = 1; end
      end
    end
  end

  always @(negedge clk) begin
    int pos;
    if (chk_on && !rst) begin
      pos = cyc - m_start;
      chk("m_clk_div", 32'(clk_div), 32'(m_run && pos < m_h));
      chk("m_tick", 32'(tick), 32'(m_run && pos == 0));
      chk("m_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
      chk("m_cur_div", 32'(cur_div), 32'(m_n));
      chk("m_cur_high", 32'(cur_high), 32'(m_h));
    end
  end

  task automatic send_cfg(input logic [W-1:0] d, input logic [W-1:0] h);
    int w = 0;
    cfg_div = d; cfg_high = h; cfg_valid = 1'b1;
    while (!cfg_ready && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_accept_timeout", 32'(w < 200), 32'd1);
  endtask

  task automatic wait_tick();
    int w = 0;
    @(negedge clk);
    while (!tick && w < 200) begin @(negedge clk); w++; end
    chk("tick_timeout", 32'(w < 200), 32'd1);
  endtask

  // Called on a negedge showing tick; returns on the negedge showing the next tick.
  task automatic measure(input int n_exp, input int h_exp, input string tag);
    int n = 0;
    int h = 0;
    do begin
      h += int'(clk_div);
      n++;
      @(negedge clk);
    end while (!tick && n < 200);
    chk({tag, "_period"}, 32'(n), 32'(n_exp));
    chk({tag, "_high"}, 32'(h), 32'(h_exp));
  endtask

  initial begin
    bit [4:0] pat;
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1; chk_on = 1'b1;
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cur_div", 32'(cur_div), 32'd64);
    chk("rst_cur_high", 32'(cur_high), 32'd32);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    chk("first_tick", 32'(tick), 32'd1);
    chk("first_clk_div", 32'(clk_div), 32'd1);
    measure(64, 32, "dflt_a");
    measure(64, 32, "dflt_b");

    // en dropped at count 10, then restarted
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("stop_clk_div", 32'(clk_div), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("restart_tick", 32'(tick), 32'd1);
    measure(64, 32, "restart");

    // config accepted at count 20, applied at the next wrap
    repeat (20) @(negedge clk);
    send_cfg(16'd10, 16'd3);
    chk("pend_ready", 32'(cfg_ready), 32'd0);
    chk("pend_cur_div", 32'(cur_div), 32'd64);
    wait_tick();
    chk("wrap_cur_div", 32'(cur_div), 32'd10);
    chk("wrap_cur_high", 32'(cur_high), 32'd3);
    chk("wrap_ready", 32'(cfg_ready), 32'd1);
    measure(10, 3, "div10");

    // clamps
    send_cfg(16'd0, 16'd0);
    wait_tick();
    chk("clamp0_div", 32'(cur_div), 32'd2);
    chk("clamp0_high", 32'(cur_high), 32'd1);
    measure(2, 1, "div2_a");
    measure(2, 1, "div2_b");
    send_cfg(16'd4, 16'd9);
    wait_tick();
    chk("clamp4_div", 32'(cur_div), 32'd4);
    chk("clamp4_high", 32'(cur_high), 32'd3);
    measure(4, 3, "div4");

    // config in IDLE lands immediately
    en = 1'b0;
    repeat (2) @(negedge clk);
    send_cfg(16'd5, 16'd2);
    chk("idle_cur_div", 32'(cur_div), 32'd5);
    chk("idle_cur_high", 32'(cur_high), 32'd2);
    chk("idle_ready", 32'(cfg_ready), 32'd1);
    en = 1'b1;
    pat = 5'b00011;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("div5_clk_div", 32'(clk_div), 32'(pat[i % 5]));
      chk("div5_tick", 32'(tick), 32'(i % 5 == 0));
      @(negedge clk);
    end

    // async reset mid-period with a pending config
    wait_tick();
    send_cfg(16'd7, 16'd3);
    chk("pre_rst_clk_div", 32'(clk_div), 32'd1);
    chk("pre_rst_ready", 32'(cfg_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_clk_div", 32'(clk_div), 32'd0);
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_cur_div", 32'(cur_div), 32'd64);
    chk("async_cur_high", 32'(cur_high), 32'd32);
    chk("async_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tick", 32'(tick), 32'd1);
    measure(64, 32, "post_rst");
    chk("post_rst_cur_div", 32'(cur_div), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
